// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types and constants for the I2C command sequencer.
// Command word layout is {rw, data}; rw=0 write, rw=1 read.
package i2c_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_GAP   = 2'd3
   } seq_state_t;

   localparam int   CMD_W    = 9;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_seq_fifo.sv
// i2c_seq_fifo: synchronous FIFO with combinational head read.
// Pointers carry one extra MSB so full and empty are distinguishable.
// A push into a full FIFO is accepted when a pop happens on the same edge;
// a pop of an empty FIFO is ignored.
module i2c_seq_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

   // Pointer update; both ends wrap modulo depth via the low bits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host write/read commands and issues them one at
// a time to an i2c_master_rw (start pulse, rw, din), waits for done, pushes
// read bytes into a return FIFO and enforces an idle gap between transfers.
// Optional done watchdog: define I2C_SEQ_TIMEOUT_EN to enable it (adds the
// TIMEOUT_CYCLES parameter); without it WAIT waits for m_done indefinitely.
module i2c_cmd_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int CMD_DEPTH  = 4,
   parameter int RD_DEPTH   = 4,
   parameter int GAP_CYCLES = 8
`ifdef I2C_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 4096
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic [7:0] rd_data,
   output logic       m_start,
   output logic       m_rw,
   output logic [7:0] m_din,
   input  logic       m_done,
   input  logic [7:0] m_rx_data,
   output logic       busy,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;

   logic [CMD_W-1:0] w_cmd_wdata;
   logic [CMD_W-1:0] w_cmd_head;
   logic             w_cmd_push;
   logic             w_cmd_pop;
   logic             w_cmd_full;
   logic             w_cmd_empty;

   logic             w_rd_push;
   logic             w_rd_full;
   logic             w_rd_empty;

   logic             r_m_start;
   logic             r_m_rw;
   logic [7:0]       r_m_din;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             w_gap_done;
   logic             w_to_hit;
   logic             r_timeout_err;

   assign w_cmd_wdata = {cmd_rw, cmd_data};
   assign w_cmd_push  = cmd_valid & ~w_cmd_full;

   i2c_seq_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (w_cmd_push),
      .i_wdata (w_cmd_wdata),
      .i_pop   (w_cmd_pop),
      .o_rdata (w_cmd_head),
      .o_full  (w_cmd_full),
      .o_empty (w_cmd_empty)
   );

   i2c_seq_fifo #(.WIDTH(8), .DEPTH(RD_DEPTH)) u_rd_fifo (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_push  (w_rd_push),
      .i_wdata (m_rx_data),
      .i_pop   (rd_ready),
      .o_rdata (rd_data),
      .o_full  (w_rd_full),
      .o_empty (w_rd_empty)
   );

   assign cmd_ready   = ~w_cmd_full;
   assign rd_valid    = ~w_rd_empty;
   assign busy        = (r_state != ST_IDLE) | ~w_cmd_empty;
   assign m_start     = r_m_start;
   assign m_rw        = r_m_rw;
   assign m_din       = r_m_din;
   assign timeout_err = r_timeout_err;
   assign w_gap_done  = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, command pop and read-data push.
   // A read is only issued while the read FIFO has a free slot; nothing is in
   // flight in IDLE, so "not full" is the whole backpressure condition.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd_pop   = 1'b0;
      w_rd_push   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_cmd_empty && !m_done &&
                (w_cmd_head[8] == RW_WRITE || !w_rd_full))
               w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_cmd_pop   = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (m_done) begin
               w_rd_push   = (r_m_rw == RW_READ);
               w_state_nxt = ST_GAP;
            end else if (w_to_hit) begin
               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (w_gap_done && !m_done) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Master-facing registers: start pulse during the ISSUE->WAIT edge, rw/din
   // latched with it and held until the next issue. Gap counter runs in GAP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_start <= 1'b0;
         r_m_rw    <= 1'b0;
         r_m_din   <= 8'h00;
         r_gap_cnt <= '0;
      end else begin
         r_m_start <= (r_state == ST_ISSUE);
         if (r_state == ST_ISSUE) begin
            r_m_rw  <= w_cmd_head[8];
            r_m_din <= w_cmd_head[7:0];
         end
         if (r_state == ST_GAP) begin
            if (!w_gap_done) r_gap_cnt <= r_gap_cnt + 1'b1;
         end else begin
            r_gap_cnt <= '0;
         end
      end
   end

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_to_cnt;

   assign w_to_hit = (r_state == ST_WAIT) && !m_done &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Watchdog: counts cycles spent in WAIT, cleared everywhere else.
   always_ff @(posedge clk) begin
      if (rst)                    r_to_cnt <= '0;
      else if (r_state == ST_WAIT) r_to_cnt <= r_to_cnt + 1'b1;
      else                        r_to_cnt <= '0;
   end
`else
   assign w_to_hit = 1'b0;
`endif

   // Sticky error flag; a timeout on the same cycle as err_clr wins.
   // Without the watchdog w_to_hit is constant 0 and this stays 0.
   always_ff @(posedge clk) begin
      if (rst)           r_timeout_err <= 1'b0;
      else if (w_to_hit) r_timeout_err <= 1'b1;
      else if (err_clr)  r_timeout_err <= 1'b0;
   end

endmodule
